// File: rtl/burst_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : burst_memory
//  Description : Memory array owner with multi-beat wrapping read bursts,
//                single-word writes and a hardware clear sequence. Control
//                logic is held in asynchronous active-high reset; the array
//                itself is never touched by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_memory #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [LEN_WIDTH-1:0]  read_len,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  read_last,
    output logic                  busy,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  clear
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;      // next burst address, or next clear address
    logic [LEN_WIDTH-1:0]    count_q;    // beats still to emit after the current one
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    read_valid_q;
    logic                    read_last_q;

    // Array starts all-zero at power-up; reset never reaches it.
    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1] = '{default: '0};

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Select the single array write port: clear owns it while accepted/running,
    // otherwise the external write strobe (usable in IDLE and BURST).
    always_comb begin
        mem_we    = write;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    mem_wdata = FILL;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = FILL;
            end
            default: begin
            end
        endcase
    end

    // Array write; reads elsewhere see the pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            read_last_q  <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            read_last_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        // Address 0 is written on this edge, so continue from 1.
                        state_q <= S_CLEAR;
                        ptr_q   <= c_ADDR_ONE;
                    end else if (read) begin
                        read_data_q  <= mem_q[read_addr];
                        read_valid_q <= 1'b1;
                        read_last_q  <= (read_len == '0);
                        ptr_q        <= read_addr + c_ADDR_ONE;
                        count_q      <= read_len;
                        state_q      <= (read_len == '0) ? S_IDLE : S_BURST;
                    end
                end
                S_BURST: begin
                    read_data_q  <= mem_q[ptr_q];
                    read_valid_q <= 1'b1;
                    ptr_q        <= ptr_q + c_ADDR_ONE;
                    count_q      <= count_q - c_LEN_ONE;
                    if (count_q == c_LEN_ONE) begin
                        read_last_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (ptr_q == c_ADDR_LAST) begin
                        state_q <= S_IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + c_ADDR_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign read_last  = read_last_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_burst_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_burst_memory
//  Description : Self-checking bench for burst_memory. A full-size instance
//                and a 16-word instance (FILL=0xFF) are driven side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_memory;

    logic        clk;
    logic        rst;

    // Full-size instance
    logic        rd, wr, clr;
    logic [11:0] rd_addr, wr_addr;
    logic [3:0]  rd_len;
    logic [7:0]  wr_data, rdata;
    logic        rvalid, rlast, rbusy;

    // Small instance
    logic        s_rd, s_wr, s_clr;
    logic [3:0]  s_rd_addr, s_wr_addr, s_rd_len;
    logic [7:0]  s_wr_data, s_rdata;
    logic        s_rvalid, s_rlast, s_busy;

    int          errors = 0;
    int          checks = 0;

    logic [7:0]  model  [4096];
    logic [7:0]  smodel [16];

    burst_memory dut (
        .clk(clk), .rst(rst),
        .read(rd), .read_addr(rd_addr), .read_len(rd_len),
        .read_data(rdata), .read_valid(rvalid), .read_last(rlast), .busy(rbusy),
        .write(wr), .write_addr(wr_addr), .write_data(wr_data), .clear(clr)
    );

    burst_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LEN_WIDTH(4), .FILL(8'hFF)) dut_s (
        .clk(clk), .rst(rst),
        .read(s_rd), .read_addr(s_rd_addr), .read_len(s_rd_len),
        .read_data(s_rdata), .read_valid(s_rvalid), .read_last(s_rlast), .busy(s_busy),
        .write(s_wr), .write_addr(s_wr_addr), .write_data(s_wr_data), .clear(s_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // One clock: inputs are driven at negedge, outputs sampled at the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rvalid); end
        checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", rlast); end
        checks++; if (rbusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", rbusy); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_s_busy: got %b want 0", s_busy); end
        rst = 1'b0;
    endtask

    task automatic test_powerup_read();
        rd = 1'b1; rd_addr = 12'h000; rd_len = 4'd0;
        tick();
        rd = 1'b0;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL pwr_data: got %h want 00", rdata); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL pwr_valid: got %b want 1", rvalid); end
        checks++; if (rlast !== 1'b1) begin errors++; $display("FAIL pwr_last: got %b want 1", rlast); end
        checks++; if (rbusy !== 1'b0) begin errors++; $display("FAIL pwr_busy: got %b want 0", rbusy); end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL pwr_valid_drop: got %b want 0", rvalid); end
    endtask

    task automatic test_preload(input int sbase);
        for (int i = 0; i < 4096; i++) begin
            wr = 1'b1; wr_addr = 12'(i); wr_data = 8'(i % 255); model[i] = 8'(i % 255);
            s_wr = (i < 16); s_wr_addr = 4'(i); s_wr_data = 8'(sbase + i);
            if (i < 16) smodel[i] = 8'(sbase + i);
            tick();
        end
        wr = 1'b0; s_wr = 1'b0;
    endtask

    task automatic test_two_beat();
        logic [7:0] want [2];
        want[0] = 8'h02; want[1] = 8'h03;
        rd = 1'b1; rd_addr = 12'h200; rd_len = 4'd1;
        for (int k = 0; k < 2; k++) begin
            tick();
            rd = 1'b0;
            checks++; if (rdata !== want[k]) begin errors++; $display("FAIL two_data[%0d]: got %h want %h", k, rdata, want[k]); end
            checks++; if (rlast !== (k == 1)) begin errors++; $display("FAIL two_last[%0d]: got %b want %b", k, rlast, (k == 1)); end
            checks++; if (rbusy !== (k == 0)) begin errors++; $display("FAIL two_busy[%0d]: got %b want %b", k, rbusy, (k == 0)); end
        end
        tick();
        checks++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin errors++; $display("FAIL two_after: got valid=%b last=%b want 0 0", rvalid, rlast); end
    endtask

    task automatic test_wrap();
        rd = 1'b1; rd_addr = 12'hFFE; rd_len = 4'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            rd = 1'b0;
            checks++; if (rdata !== model[(4094 + k) % 4096] || rvalid !== 1'b1)
                begin errors++; $display("FAIL wrap[%0d]: got %h/%b want %h/1", k, rdata, rvalid, model[(4094 + k) % 4096]); end
            checks++; if (rlast !== (k == 3)) begin errors++; $display("FAIL wrap_last[%0d]: got %b want %b", k, rlast, (k == 3)); end
        end
        tick();
    endtask

    task automatic test_write_during_burst();
        logic [7:0] want;
        rd_addr = 12'h100; rd_len = 4'd15;
        for (int k = 0; k < 16; k++) begin
            rd = (k == 0);
            wr = (k == 2) || (k == 5);
            wr_addr = (k == 2) ? 12'h108 : 12'h105;
            wr_data = (k == 2) ? 8'hAA : 8'h55;
            tick();
            want = (k == 8) ? 8'hAA : 8'((256 + k) % 255);
            checks++; if (rdata !== want || rvalid !== 1'b1 || rlast !== (k == 15))
                begin errors++; $display("FAIL wdb_beat[%0d]: got %h/%b/%b want %h/1/%b", k, rdata, rvalid, rlast, want, (k == 15)); end
        end
        wr = 1'b0; rd = 1'b0;
        model[12'h108] = 8'hAA; model[12'h105] = 8'h55;
        tick();
        rd = 1'b1; rd_addr = 12'h105; rd_len = 4'd0;
        tick();
        rd = 1'b0;
        checks++; if (rdata !== 8'h55 || rvalid !== 1'b1) begin errors++; $display("FAIL wdb_reread: got %h/%b want 55/1", rdata, rvalid); end
        tick();
    endtask

    // Random bursts with random writes and random (possibly zero) idle gaps.
    task automatic test_random_bursts();
        int addr, len, gap, wa;
        logic [7:0] exp;
        for (int b = 0; b < 40; b++) begin
            addr = $urandom_range(0, 4095);
            len  = $urandom_range(0, 15);
            for (int k = 0; k <= len; k++) begin
                rd = (k == 0); rd_addr = 12'(addr); rd_len = 4'(len);
                exp = model[(addr + k) % 4096];
                if ($urandom_range(0, 2) == 0) begin
                    wa = (addr + $urandom_range(0, 15)) % 4096;
                    wr = 1'b1; wr_addr = 12'(wa); wr_data = 8'($urandom_range(0, 255));
                    model[wa] = wr_data;
                end else begin
                    wr = 1'b0;
                end
                tick();
                checks++; if (rdata !== exp || rvalid !== 1'b1 || rlast !== (k == len) || rbusy !== (k != len))
                    begin errors++; $display("FAIL rnd[%0d.%0d]: got d=%h v=%b l=%b b=%b want d=%h v=1 l=%b b=%b",
                        b, k, rdata, rvalid, rlast, rbusy, exp, (k == len), (k != len)); end
            end
            rd = 1'b0; wr = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                tick();
                checks++; if (rvalid !== 1'b0 || rlast !== 1'b0)
                    begin errors++; $display("FAIL rnd_gap[%0d]: got v=%b l=%b want 0 0", b, rvalid, rlast); end
            end
        end
    endtask

    // Clear wins over a simultaneous read. FILL is written on the accept edge
    // and the following DEPTH-1 edges; the last of those returns to IDLE, so
    // busy is seen for DEPTH-1 = 15 sampled cycles.
    task automatic test_clear_priority();
        int busy_cnt, valid_cnt;
        busy_cnt = 0; valid_cnt = 0;
        s_clr = 1'b1; s_rd = 1'b1; s_rd_addr = 4'd3; s_rd_len = 4'd0;
        tick();
        s_clr = 1'b0; s_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_busy) busy_cnt++;
            if (s_rvalid) valid_cnt++;
            tick();
        end
        checks++; if (busy_cnt != 15) begin errors++; $display("FAIL clr_busy_cycles: got %0d want 15", busy_cnt); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL clr_valid: got %0d want 0", valid_cnt); end
        for (int i = 0; i < 16; i++) smodel[i] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            s_rd = 1'b1; s_rd_addr = 4'(i); s_rd_len = 4'd0;
            tick();
            checks++; if (s_rdata !== smodel[i] || s_rvalid !== 1'b1)
                begin errors++; $display("FAIL clr_read[%0d]: got %h/%b want %h/1", i, s_rdata, s_rvalid, smodel[i]); end
        end
        s_rd = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_burst();
        rd = 1'b1; rd_addr = 12'h300; rd_len = 4'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            rd = 1'b0;
        end
        checks++; if (rdata !== model[12'h303] || rvalid !== 1'b1)
            begin errors++; $display("FAIL rstb_beat3: got %h/%b want %h/1", rdata, rvalid, model[12'h303]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rvalid !== 1'b0 || rlast !== 1'b0 || rbusy !== 1'b0)
            begin errors++; $display("FAIL rstb_async: got v=%b l=%b b=%b want 0 0 0", rvalid, rlast, rbusy); end
        @(negedge clk);
        rst = 1'b0;
        rd = 1'b1; rd_addr = 12'h123; rd_len = 4'd0;
        tick();
        rd = 1'b0;
        checks++; if (rdata !== model[12'h123] || rvalid !== 1'b1 || rlast !== 1'b1)
            begin errors++; $display("FAIL rstb_read: got %h/%b/%b want %h/1/1", rdata, rvalid, rlast, model[12'h123]); end
        tick();
    endtask

    task automatic test_rst_mid_clear();
        for (int i = 0; i < 16; i++) begin
            s_wr = 1'b1; s_wr_addr = 4'(i); s_wr_data = 8'(8'h40 + i); smodel[i] = 8'(8'h40 + i);
            tick();
        end
        s_wr = 1'b0;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (s_busy !== 1'b0 || s_rvalid !== 1'b0)
            begin errors++; $display("FAIL rstc_async: got b=%b v=%b want 0 0", s_busy, s_rvalid); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) smodel[i] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            s_rd = 1'b1; s_rd_addr = 4'(i); s_rd_len = 4'd0;
            tick();
            checks++; if (s_rdata !== smodel[i] || s_rvalid !== 1'b1)
                begin errors++; $display("FAIL rstc_read[%0d]: got %h/%b want %h/1", i, s_rdata, s_rvalid, smodel[i]); end
        end
        s_rd = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rd = 1'b0; rd_addr = '0; rd_len = '0; wr = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
        s_rd = 1'b0; s_rd_addr = '0; s_rd_len = '0; s_wr = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_clr = 1'b0;

        test_reset();
        test_powerup_read();
        test_preload(8'h30);
        test_two_beat();
        test_wrap();
        test_write_during_burst();
        test_random_bursts();
        test_clear_priority();
        test_rst_mid_burst();
        test_rst_mid_clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
